// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1306 text-terminal controller: FSM states,
// command opcodes and the fixed init sequence.
package oled_pkg;

    localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;
    localparam logic [7:0] CMD_DISP_ON   = 8'hAF;
    localparam logic [7:0] CMD_CHG_PUMP  = 8'h8D;
    localparam logic [7:0] CMD_PRECHARGE = 8'hD9;
    localparam logic [7:0] CMD_CONTRAST  = 8'h81;
    localparam logic [7:0] CMD_ADDR_MODE = 8'h20;
    localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;
    localparam logic [7:0] CMD_SEG_REMAP = 8'hA1;
    localparam logic [7:0] CMD_COM_SCAN  = 8'hC8;
    localparam logic [7:0] CMD_COM_PINS  = 8'hDA;

    localparam int unsigned INIT_LEN  = 12;
    localparam int unsigned ADDR_LEN  = 6;
    localparam int unsigned GLYPH_LEN = 8;

    typedef enum logic [4:0] {
        StPwrVdd, StWait, StSend, StPwrAe, StRstLo, StRstHi, StInit, StClrCmd, StClrData,
        StVbatOn, StDispOn, StReady, StNl, StDrawCmd, StDrawData, StPwrDnVbat, StPwrDnVdd,
        StOff
    } state_e;

    function automatic logic [7:0] init_byte(input logic [3:0] idx, input logic [7:0] contrast,
                                             input logic big_panel);
        logic [7:0] b;
        case (idx)
            4'd0:    b = CMD_CHG_PUMP;
            4'd1:    b = 8'h14;
            4'd2:    b = CMD_PRECHARGE;
            4'd3:    b = 8'hF1;
            4'd4:    b = CMD_CONTRAST;
            4'd5:    b = contrast;
            4'd6:    b = CMD_SEG_REMAP;
            4'd7:    b = CMD_COM_SCAN;
            4'd8:    b = CMD_COM_PINS;
            4'd9:    b = big_panel ? 8'h12 : 8'h02;
            4'd10:   b = CMD_ADDR_MODE;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/char_rom.sv
// ASCII to 8x8 glyph lookup; each byte is one pixel column, first column in bits 63:56.
module char_rom (
    input  logic [6:0]  i_char,
    output logic [63:0] o_glyph
);
    always_comb begin
        o_glyph = 64'hFF81_8181_8181_81FF;
        case (i_char)
            7'h20: o_glyph = 64'h0000_0000_0000_0000;
            7'h30: o_glyph = 64'h3E51_4945_3E00_0000;
            7'h31: o_glyph = 64'h0042_7F40_0000_0000;
            7'h41: o_glyph = 64'h7C12_1112_7C00_0000;
            7'h42: o_glyph = 64'h7F49_4949_3600_0000;
            7'h43: o_glyph = 64'h3E41_4141_2200_0000;
            7'h48: o_glyph = 64'h7F08_0808_7F00_0000;
            default: ;
        endcase
    end
endmodule

// File: rtl/oled_spi_tx.sv
// Byte serializer: MSB first, SCLK idles high, data changes on the falling edge.
// One extra idle SCLK period follows each byte before o_done.
module oled_spi_tx #(
    parameter int unsigned SCLK_DIV = 10
) (
    input  logic       i_clk,
    input  logic       i_arst_n,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_busy,
    output logic       o_done,
    output logic       sclk,
    output logic       sdin
);
    localparam int unsigned CNT_W = $clog2(SCLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SCLK_DIV / 2 - 1);

    logic             busy_q;
    logic [7:0]       sh_q;
    logic [3:0]       bit_q;
    logic [CNT_W-1:0] cnt_q;

    assign o_busy = busy_q;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            busy_q <= 1'b0;
            sh_q   <= 8'h00;
            bit_q  <= 4'd0;
            cnt_q  <= '0;
            o_done <= 1'b0;
            sclk   <= 1'b1;
            sdin   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (!busy_q) begin
                if (i_start) begin
                    busy_q <= 1'b1;
                    sh_q   <= i_byte;
                    sdin   <= i_byte[7];
                    sclk   <= 1'b0;
                    cnt_q  <= '0;
                    bit_q  <= 4'd0;
                end
            end else if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                if (bit_q == 4'd8) begin
                    busy_q <= 1'b0;
                    o_done <= 1'b1;
                end else begin
                    bit_q <= bit_q + 4'd1;
                    // After bit 7, hold SCLK high for the inter-byte gap period.
                    if (bit_q != 4'd7) begin
                        sclk <= 1'b0;
                        sdin <= sh_q[6];
                        sh_q <= {sh_q[6:0], 1'b0};
                    end
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CNT_HALF && bit_q != 4'd8) begin
                    sclk <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/oled_term_cntrl.sv
// SSD1306 text terminal: power sequencing, init, clear, and 8x8 glyph drawing at an
// auto-advancing cursor that wraps without scrolling.
module oled_term_cntrl
    import oled_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned SCLK_DIV = 10,
    parameter int unsigned COLS     = 128,
    parameter int unsigned PAGES    = 4,
    parameter logic [7:0]  CONTRAST = 8'hFF,
    parameter int unsigned VDD_MS   = 1,
    parameter int unsigned RST_MS   = 1,
    parameter int unsigned VBAT_MS  = 100
) (
    input  logic       i_clk,
    input  logic       i_arst_n,
    input  logic [6:0] i_char,
    input  logic       i_char_valid,
    output logic       o_char_ready,
    input  logic       i_clear,
    input  logic       i_pwr_off,
    output logic       o_on,
    output logic       o_oled_vdd,
    output logic       o_oled_vbat,
    output logic       o_oled_rst_n,
    output logic       o_oled_dc_n,
    output logic       o_oled_sclk,
    output logic       o_oled_sdin
);
    localparam int unsigned CYC_PER_MS = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
    localparam int unsigned CYC_W      = $clog2(CYC_PER_MS + 1);
    localparam int unsigned NBYTES     = COLS * PAGES;
    localparam int unsigned BC_W       = $clog2(NBYTES + 1);

    state_e           state_q, wait_nxt_q, ret_q;
    logic [15:0]      ms_q;
    logic [CYC_W-1:0] cyc_q;
    logic [3:0]       idx_q;
    logic [BC_W-1:0]  byte_cnt_q;
    logic [3:0]       col_q;
    logic [2:0]       page_q;
    logic [6:0]       char_q;
    logic             tx_start_q;
    logic [7:0]       tx_byte_q;
    logic             tx_busy, tx_done;
    logic [63:0]      glyph;
    logic [7:0]       clr_cmd, draw_cmd, glyph_byte;
    logic             last_col, last_page;

    char_rom u_char_rom (
        .i_char  (char_q),
        .o_glyph (glyph)
    );

    oled_spi_tx #(
        .SCLK_DIV (SCLK_DIV)
    ) u_spi_tx (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_start  (tx_start_q),
        .i_byte   (tx_byte_q),
        .o_busy   (tx_busy),
        .o_done   (tx_done),
        .sclk     (o_oled_sclk),
        .sdin     (o_oled_sdin)
    );

    assign o_char_ready = (state_q == StReady) && !tx_busy && !i_clear && !i_pwr_off;
    assign last_col     = (col_q == 4'(COLS / 8 - 1));
    assign last_page    = (page_q == 3'(PAGES - 1));

    always_comb begin
        clr_cmd    = 8'h00;
        draw_cmd   = 8'h00;
        glyph_byte = glyph[{3'd7 - idx_q[2:0], 3'b000} +: 8];
        case (idx_q)
            4'd0: begin clr_cmd = CMD_COL_ADDR;  draw_cmd = CMD_COL_ADDR;             end
            4'd1: begin clr_cmd = 8'h00;         draw_cmd = {1'b0, col_q, 3'b000};    end
            4'd2: begin clr_cmd = 8'(COLS - 1);  draw_cmd = {1'b0, col_q, 3'b111};    end
            4'd3: begin clr_cmd = CMD_PAGE_ADDR; draw_cmd = CMD_PAGE_ADDR;            end
            4'd4: begin clr_cmd = 8'h00;         draw_cmd = {5'd0, page_q};           end
            4'd5: begin clr_cmd = 8'(PAGES - 1); draw_cmd = {5'd0, page_q};           end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q      <= StPwrVdd;
            wait_nxt_q   <= StPwrVdd;
            ret_q        <= StPwrVdd;
            ms_q         <= 16'd0;
            cyc_q        <= '0;
            idx_q        <= 4'd0;
            byte_cnt_q   <= '0;
            col_q        <= 4'd0;
            page_q       <= 3'd0;
            char_q       <= 7'd0;
            tx_start_q   <= 1'b0;
            tx_byte_q    <= 8'h00;
            o_on         <= 1'b0;
            o_oled_vdd   <= 1'b0;
            o_oled_vbat  <= 1'b0;
            o_oled_rst_n <= 1'b1;
            o_oled_dc_n  <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            unique case (state_q)
                StPwrVdd: begin
                    o_oled_vdd <= 1'b1;
                    ms_q       <= 16'(VDD_MS);
                    cyc_q      <= '0;
                    wait_nxt_q <= StPwrAe;
                    state_q    <= StWait;
                end
                StWait: begin
                    if (cyc_q == CYC_W'(CYC_PER_MS - 1)) begin
                        cyc_q <= '0;
                        if (ms_q <= 16'd1) state_q <= wait_nxt_q;
                        else               ms_q    <= ms_q - 16'd1;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                StSend: begin
                    if (tx_done) begin
                        state_q <= ret_q;
                        if (ret_q == StReady) o_on <= 1'b1;
                    end
                end
                StPwrAe: begin
                    {tx_start_q, tx_byte_q, o_oled_dc_n} <= {1'b1, CMD_DISP_OFF, 1'b0};
                    ret_q   <= StRstLo;
                    state_q <= StSend;
                end
                StRstLo: begin
                    o_oled_rst_n <= 1'b0;
                    ms_q         <= 16'(RST_MS);
                    cyc_q        <= '0;
                    wait_nxt_q   <= StRstHi;
                    state_q      <= StWait;
                end
                StRstHi: begin
                    o_oled_rst_n <= 1'b1;
                    ms_q         <= 16'(RST_MS);
                    cyc_q        <= '0;
                    idx_q        <= 4'd0;
                    wait_nxt_q   <= StInit;
                    state_q      <= StWait;
                end
                StInit: begin
                    if (idx_q == 4'(INIT_LEN)) begin
                        idx_q   <= 4'd0;
                        state_q <= StClrCmd;
                    end else begin
                        tx_start_q  <= 1'b1;
                        tx_byte_q   <= init_byte(idx_q, CONTRAST, PAGES > 4);
                        o_oled_dc_n <= 1'b0;
                        idx_q       <= idx_q + 4'd1;
                        ret_q       <= StInit;
                        state_q     <= StSend;
                    end
                end
                StClrCmd: begin
                    if (idx_q == 4'(ADDR_LEN)) begin
                        byte_cnt_q <= '0;
                        state_q    <= StClrData;
                    end else begin
                        {tx_start_q, tx_byte_q, o_oled_dc_n} <= {1'b1, clr_cmd, 1'b0};
                        idx_q   <= idx_q + 4'd1;
                        ret_q   <= StClrCmd;
                        state_q <= StSend;
                    end
                end
                StClrData: begin
                    if (byte_cnt_q == BC_W'(NBYTES)) begin
                        col_q   <= 4'd0;
                        page_q  <= 3'd0;
                        // o_on distinguishes a user clear from the power-up clear.
                        state_q <= o_on ? StReady : StVbatOn;
                    end else begin
                        {tx_start_q, tx_byte_q, o_oled_dc_n} <= {1'b1, 8'h00, 1'b1};
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        ret_q      <= StClrData;
                        state_q    <= StSend;
                    end
                end
                StVbatOn: begin
                    o_oled_vbat <= 1'b1;
                    ms_q        <= 16'(VBAT_MS);
                    cyc_q       <= '0;
                    wait_nxt_q  <= StDispOn;
                    state_q     <= StWait;
                end
                StDispOn: begin
                    {tx_start_q, tx_byte_q, o_oled_dc_n} <= {1'b1, CMD_DISP_ON, 1'b0};
                    ret_q   <= StReady;
                    state_q <= StSend;
                end
                StReady: begin
                    if (i_pwr_off) begin
                        {tx_start_q, tx_byte_q, o_oled_dc_n} <= {1'b1, CMD_DISP_OFF, 1'b0};
                        ret_q   <= StPwrDnVbat;
                        state_q <= StSend;
                    end else if (i_clear) begin
                        idx_q   <= 4'd0;
                        state_q <= StClrCmd;
                    end else if (o_char_ready && i_char_valid) begin
                        char_q <= i_char;
                        idx_q  <= 4'd0;
                        if (i_char == 7'h0A) begin
                            col_q   <= 4'd0;
                            page_q  <= last_page ? 3'd0 : page_q + 3'd1;
                            state_q <= StNl;
                        end else begin
                            state_q <= StDrawCmd;
                        end
                    end
                end
                StNl: state_q <= StReady;
                StDrawCmd: begin
                    if (idx_q == 4'(ADDR_LEN)) begin
                        idx_q   <= 4'd0;
                        state_q <= StDrawData;
                    end else begin
                        {tx_start_q, tx_byte_q, o_oled_dc_n} <= {1'b1, draw_cmd, 1'b0};
                        idx_q   <= idx_q + 4'd1;
                        ret_q   <= StDrawCmd;
                        state_q <= StSend;
                    end
                end
                StDrawData: begin
                    if (idx_q == 4'(GLYPH_LEN)) begin
                        if (last_col) begin
                            col_q  <= 4'd0;
                            page_q <= last_page ? 3'd0 : page_q + 3'd1;
                        end else begin
                            col_q <= col_q + 4'd1;
                        end
                        state_q <= StReady;
                    end else begin
                        {tx_start_q, tx_byte_q, o_oled_dc_n} <= {1'b1, glyph_byte, 1'b1};
                        idx_q   <= idx_q + 4'd1;
                        ret_q   <= StDrawData;
                        state_q <= StSend;
                    end
                end
                StPwrDnVbat: begin
                    o_oled_vbat <= 1'b0;
                    ms_q        <= 16'(VBAT_MS);
                    cyc_q       <= '0;
                    wait_nxt_q  <= StPwrDnVdd;
                    state_q     <= StWait;
                end
                StPwrDnVdd: begin
                    o_oled_vdd <= 1'b0;
                    o_on       <= 1'b0;
                    state_q    <= StOff;
                end
                StOff: begin
                    if (!i_pwr_off) state_q <= StPwrVdd;
                end
                default: state_q <= StPwrVdd;
            endcase
        end
    end
endmodule

// File: tb/tb_oled_term_cntrl.sv
// Self-checking bench: an SPI monitor decodes bytes and pops them against a scoreboard
// queue that each scenario fills as it drives stimulus.
`timescale 1ns/1ps
module tb_oled_term_cntrl;
    localparam int unsigned CLK_FREQ = 10_000;
    localparam int unsigned SCLK_DIV = 2;
    localparam int unsigned COLS     = 128;
    localparam int unsigned PAGES    = 4;
    localparam int unsigned VDD_MS   = 1;
    localparam int unsigned RST_MS   = 1;
    localparam int unsigned VBAT_MS  = 100;
    localparam int unsigned CYC_MS   = CLK_FREQ / 1000;
    localparam logic [7:0]  RESET_PAT = 8'b0010_1000;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic [6:0] i_char = 7'd0;
    logic       i_char_valid = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_pwr_off = 1'b0;
    logic       o_char_ready, o_on, o_oled_vdd, o_oled_vbat, o_oled_rst_n;
    logic       o_oled_dc_n, o_oled_sclk, o_oled_sdin;

    int         checks = 0;
    int         errors = 0;
    int         rx_count = 0;
    logic [8:0] expq[$];
    int         m_col = 0;
    int         m_page = 0;

    oled_term_cntrl #(
        .CLK_FREQ (CLK_FREQ),
        .SCLK_DIV (SCLK_DIV),
        .COLS     (COLS),
        .PAGES    (PAGES),
        .CONTRAST (8'hFF),
        .VDD_MS   (VDD_MS),
        .RST_MS   (RST_MS),
        .VBAT_MS  (VBAT_MS)
    ) dut (
        .i_clk        (clk),
        .i_arst_n     (arst_n),
        .i_char       (i_char),
        .i_char_valid (i_char_valid),
        .o_char_ready (o_char_ready),
        .i_clear      (i_clear),
        .i_pwr_off    (i_pwr_off),
        .o_on         (o_on),
        .o_oled_vdd   (o_oled_vdd),
        .o_oled_vbat  (o_oled_vbat),
        .o_oled_rst_n (o_oled_rst_n),
        .o_oled_dc_n  (o_oled_dc_n),
        .o_oled_sclk  (o_oled_sclk),
        .o_oled_sdin  (o_oled_sdin)
    );

    always #5 clk = ~clk;

    initial begin
        #(98_000 * 10);
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    // SPI monitor: the panel samples SDIN on the SCLK rising edge.
    logic [7:0] mon_sh = 8'h00;
    int         mon_n = 0;
    logic [8:0] mon_exp;
    always @(posedge o_oled_sclk or negedge arst_n) begin
        if (!arst_n) begin
            mon_n = 0;
        end else begin
            mon_sh = {mon_sh[6:0], o_oled_sdin};
            mon_n++;
            if (mon_n == 8) begin
                mon_n = 0;
                rx_count++;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL spi_byte: got dc=%0b byte=%02h, required no traffic",
                             o_oled_dc_n, mon_sh);
                end else begin
                    mon_exp = expq.pop_front();
                    if ({o_oled_dc_n, mon_sh} !== mon_exp) begin
                        errors++;
                        $display("FAIL spi_byte #%0d: got dc=%0b byte=%02h, required dc=%0b byte=%02h",
                                 rx_count, o_oled_dc_n, mon_sh, mon_exp[8], mon_exp[7:0]);
                    end
                end
            end
        end
    end

    function automatic logic [63:0] ref_glyph(input logic [6:0] c);
        if (c == 7'h41) return 64'h7C12_1112_7C00_0000;
        if (c == 7'h42) return 64'h7F49_4949_3600_0000;
        return 64'h0;
    endfunction

    task automatic push_cmd(input logic [7:0] b);
        expq.push_back({1'b0, b});
    endtask

    task automatic push_clear();
        logic [7:0] hdr [6];
        hdr = '{8'h21, 8'h00, 8'(COLS - 1), 8'h22, 8'h00, 8'(PAGES - 1)};
        foreach (hdr[i]) push_cmd(hdr[i]);
        for (int i = 0; i < COLS * PAGES; i++) expq.push_back(9'h100);
        m_col = 0;
        m_page = 0;
    endtask

    task automatic push_powerup();
        logic [7:0] init [12];
        init = '{8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81, 8'hFF, 8'hA1, 8'hC8, 8'hDA, 8'h02,
                 8'h20, 8'h00};
        push_cmd(8'hAE);
        foreach (init[i]) push_cmd(init[i]);
        push_clear();
        push_cmd(8'hAF);
    endtask

    task automatic push_glyph(input logic [6:0] c);
        logic [63:0] g;
        g = ref_glyph(c);
        push_cmd(8'h21);
        push_cmd(8'(m_col * 8));
        push_cmd(8'(m_col * 8 + 7));
        push_cmd(8'h22);
        push_cmd(8'(m_page));
        push_cmd(8'(m_page));
        for (int i = 7; i >= 0; i--) expq.push_back({1'b1, g[i*8 +: 8]});
        if (m_col == COLS / 8 - 1) begin
            m_col = 0;
            m_page = (m_page == PAGES - 1) ? 0 : m_page + 1;
        end else begin
            m_col++;
        end
    endtask

    task automatic send_char(input logic [6:0] c);
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (o_char_ready === 1'b1) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_char_ready: o_char_ready=%b, required 1 within 2000 cycles",
                     o_char_ready);
        end
        i_char = c;
        i_char_valid = 1'b1;
        @(posedge clk); #1;
        i_char_valid = 1'b0;
    endtask

    task automatic wait_on(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (o_on === 1'b1 && o_char_ready === 1'b1) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        bit ok;
        int base, lo;
        arst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_oled_vdd, o_oled_vbat, o_oled_rst_n, o_oled_dc_n, o_oled_sclk, o_oled_sdin,
             o_char_ready, o_on} !== RESET_PAT) begin
            errors++;
            $display("FAIL reset_values: got %b, required %b", {o_oled_vdd, o_oled_vbat,
                     o_oled_rst_n, o_oled_dc_n, o_oled_sclk, o_oled_sdin, o_char_ready, o_on},
                     RESET_PAT);
        end
        base = rx_count;
        push_powerup();
        @(negedge clk) arst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({o_oled_vdd, o_oled_vbat, o_oled_rst_n} !== 3'b101) begin
            errors++;
            $display("FAIL vdd_on: got vdd/vbat/rst_n=%b, required 101",
                     {o_oled_vdd, o_oled_vbat, o_oled_rst_n});
        end
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (o_oled_rst_n === 1'b0) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!ok || rx_count - base != 1) begin
            errors++;
            $display("FAIL rst_lo_after_ae: rst_n low seen=%0b bytes=%0d, required 1 and 1",
                     ok, rx_count - base);
        end
        lo = 0;
        while (o_oled_rst_n !== 1'b1 && lo < 100) begin
            @(posedge clk); #1;
            lo++;
        end
        checks++;
        if (lo < CYC_MS * RST_MS || lo > CYC_MS * RST_MS + 2) begin
            errors++;
            $display("FAIL rst_width: got %0d cycles, required %0d..%0d", lo, CYC_MS * RST_MS,
                     CYC_MS * RST_MS + 2);
        end
        checks++;
        if (o_oled_vbat !== 1'b0) begin
            errors++;
            $display("FAIL vbat_early: got %b, required 0", o_oled_vbat);
        end
        wait_on(20000, ok);
        checks++;
        if (!ok || expq.size() != 0 || o_oled_vbat !== 1'b1 || rx_count - base != 532) begin
            errors++;
            $display("FAIL powerup_done: on=%0b pending=%0d vbat=%b bytes=%0d, required 1 0 1 532",
                     ok, expq.size(), o_oled_vbat, rx_count - base);
        end
    endtask

    task automatic test_char_a();
        bit saw_hi = 0;
        bit ok = 0;
        push_glyph(7'h41);
        send_char(7'h41);
        for (int i = 0; i < 1000 && expq.size() != 0; i++) begin
            if (o_char_ready !== 1'b0) saw_hi = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (saw_hi || expq.size() != 0) begin
            errors++;
            $display("FAIL draw_ready_low: ready_high_seen=%0b pending=%0d, required 0 0",
                     saw_hi, expq.size());
        end
        for (int i = 0; i < 100; i++) begin
            if (o_char_ready === 1'b1) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL draw_ready_return: o_char_ready=%b, required 1", o_char_ready);
        end
    endtask

    task automatic test_wrap_newline();
        bit ok;
        for (int i = 0; i < 15; i++) begin
            push_glyph(7'h41);
            send_char(7'h41);
        end
        push_glyph(7'h42);
        send_char(7'h42);
        for (int n = 0; n < 3; n++) begin
            send_char(7'h0A);
            m_col = 0;
            m_page = (m_page == PAGES - 1) ? 0 : m_page + 1;
            checks++;
            if (o_char_ready !== 1'b0) begin
                errors++;
                $display("FAIL nl_ready_drop: got %b, required 0", o_char_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (o_char_ready !== 1'b1) begin
                errors++;
                $display("FAIL nl_ready_back: got %b, required 1", o_char_ready);
            end
        end
        push_glyph(7'h41);
        send_char(7'h41);
        wait_on(1000, ok);
        checks++;
        if (!ok || expq.size() != 0) begin
            errors++;
            $display("FAIL wrap_drain: ready=%0b pending=%0d, required 1 0", ok, expq.size());
        end
    endtask

    task automatic test_pwr_off();
        bit ok;
        int base, n;
        wait_on(2000, ok);
        base = rx_count;
        push_cmd(8'hAE);
        i_char = 7'h41;
        i_char_valid = 1'b1;
        i_clear = 1'b1;
        i_pwr_off = 1'b1;
        #1;
        checks++;
        if (o_char_ready !== 1'b0) begin
            errors++;
            $display("FAIL pwr_off_ready: got %b, required 0", o_char_ready);
        end
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (o_oled_vbat === 1'b0) begin ok = 1; break; end
        end
        checks++;
        if (!ok || expq.size() != 0 || o_oled_vdd !== 1'b1) begin
            errors++;
            $display("FAIL vbat_off: seen=%0b pending=%0d vdd=%b, required 1 0 1", ok,
                     expq.size(), o_oled_vdd);
        end
        n = 0;
        while (o_oled_vdd !== 1'b0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n < CYC_MS * VBAT_MS || n > CYC_MS * VBAT_MS + 3) begin
            errors++;
            $display("FAIL vbat_wait: got %0d cycles, required %0d..%0d", n, CYC_MS * VBAT_MS,
                     CYC_MS * VBAT_MS + 3);
        end
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if ({o_oled_vdd, o_oled_vbat, o_on, o_char_ready} !== 4'b0000 || rx_count - base != 1)
        begin
            errors++;
            $display("FAIL off_hold: vdd/vbat/on/ready=%b bytes=%0d, required 0000 1",
                     {o_oled_vdd, o_oled_vbat, o_on, o_char_ready}, rx_count - base);
        end
        base = rx_count;
        push_powerup();
        i_pwr_off = 1'b0;
        i_clear = 1'b0;
        i_char_valid = 1'b0;
        wait_on(20000, ok);
        checks++;
        if (!ok || expq.size() != 0 || rx_count - base != 532) begin
            errors++;
            $display("FAIL repowerup: on=%0b pending=%0d bytes=%0d, required 1 0 532", ok,
                     expq.size(), rx_count - base);
        end
    endtask

    task automatic test_clear_mid_draw();
        bit ok;
        int base;
        base = rx_count;
        push_glyph(7'h42);
        send_char(7'h42);
        for (int i = 0; i < 500 && rx_count - base < 3; i++) begin
            @(posedge clk); #1;
        end
        i_clear = 1'b1;
        push_clear();
        for (int i = 0; i < 2000 && expq.size() > COLS * PAGES; i++) begin
            @(posedge clk); #1;
        end
        i_clear = 1'b0;
        wait_on(12000, ok);
        checks++;
        if (!ok || expq.size() != 0) begin
            errors++;
            $display("FAIL clear_mid_draw: ready=%0b pending=%0d, required 1 0", ok,
                     expq.size());
        end
        push_glyph(7'h41);
        send_char(7'h41);
        wait_on(1000, ok);
        checks++;
        if (!ok || expq.size() != 0) begin
            errors++;
            $display("FAIL home_after_clear: ready=%0b pending=%0d, required 1 0", ok,
                     expq.size());
        end
    endtask

    task automatic test_reset_mid_clear();
        bit ok;
        int base;
        base = rx_count;
        i_clear = 1'b1;
        push_clear();
        for (int i = 0; i < 1000 && rx_count - base < 20; i++) begin
            @(posedge clk); #1;
        end
        i_clear = 1'b0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (o_oled_sclk === 1'b0) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        #2 arst_n = 1'b0;
        #1;
        checks++;
        if (!ok || {o_oled_vdd, o_oled_vbat, o_oled_rst_n, o_oled_dc_n, o_oled_sclk,
                    o_oled_sdin, o_char_ready, o_on} !== RESET_PAT) begin
            errors++;
            $display("FAIL reset_mid_byte: mid=%0b got %b, required 1 %b", ok,
                     {o_oled_vdd, o_oled_vbat, o_oled_rst_n, o_oled_dc_n, o_oled_sclk,
                      o_oled_sdin, o_char_ready, o_on}, RESET_PAT);
        end
        expq.delete();
        repeat (3) @(posedge clk);
        base = rx_count;
        push_powerup();
        @(negedge clk) arst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o_oled_vdd !== 1'b1 || o_on !== 1'b0) begin
            errors++;
            $display("FAIL restart_vdd: vdd=%b on=%b, required 1 0", o_oled_vdd, o_on);
        end
        wait_on(20000, ok);
        checks++;
        if (!ok || expq.size() != 0 || rx_count - base != 532) begin
            errors++;
            $display("FAIL restart_powerup: on=%0b pending=%0d bytes=%0d, required 1 0 532",
                     ok, expq.size(), rx_count - base);
        end
    endtask

    initial begin
        test_reset();
        test_char_a();
        test_wrap_newline();
        test_pwr_off();
        test_clear_mid_draw();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
